// File: rtl/cu_pkg.sv
// Shared constants for the control unit: opcodes, ALU codes, FSM states, instruction classes.
// Latency: n/a (constants and pure functions only).
// Backpressure: none; optional MUL/DIV decode controlled by CU_MULDIV_EN.
package cu_pkg;

  // Instruction opcodes, IR[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation codes driven on 'operation'
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_DIV = 4'b0101;

  // FSM states
  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  // Execution classes; everything unrecognised is fetch-only
  localparam logic [2:0] CLS_NOP  = 3'd0;
  localparam logic [2:0] CLS_ALU  = 3'd1;
  localparam logic [2:0] CLS_LD   = 3'd2;
  localparam logic [2:0] CLS_ST   = 3'd3;
  localparam logic [2:0] CLS_MD   = 3'd4;
  localparam logic [2:0] CLS_HALT = 3'd5;

  function automatic logic [2:0] decode_class(input logic [4:0] opc);
    logic [2:0] cls;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CLS_ALU;
      OP_LD:                         cls = CLS_LD;
      OP_ST:                         cls = CLS_ST;
      OP_HALT:                       cls = CLS_HALT;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV:                cls = CLS_MD;
`endif
      default:                       cls = CLS_NOP;
    endcase
    return cls;
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] opc);
    logic [3:0] code;
    case (opc)
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      OP_MUL:  code = ALU_MUL;
      OP_DIV:  code = ALU_DIV;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_unit_reg_select.sv
// Register select: turns a 4-bit register index plus enable into a 16-bit one-hot strobe.
// Latency: combinational.
// Backpressure: none.
module reg_select (
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] onehot
);

  // Single bit set at the selected register when enabled, otherwise all zero
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: fetch T0..T2, decode in T3, execute up to T7; HALT absorbing until clear.
// Latency: one state per Clock; outputs decoded combinationally from current state (and IR in T3..T7).
// Backpressure: none; clear is a synchronous override. MUL/DIV sequencing enabled by CU_MULDIV_EN.
module control_unit
  import cu_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIout,
  output logic        LOout,
  output logic        MDRout,
  output logic        Cout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin_low,
  output logic        Zin_high,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [3:0]  operation,
  output logic        Run
);

  logic [3:0] state_q, state_d;
  logic [2:0] cls_q, cls_d;
  logic [3:0] alu_q, alu_d;

  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic [2:0] dec_cls;
  logic       unused_ir_low;

  logic [3:0] rin_idx, rout_idx;
  logic       rin_en, rout_en;

  assign opc           = IR[31:27];
  assign ra            = IR[26:23];
  assign rb            = IR[22:19];
  assign rc            = IR[18:15];
  assign unused_ir_low = ^IR[14:0];
  assign dec_cls       = decode_class(opc);

  // Next state; class and ALU code are captured at decode so later steps ignore opcode changes
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    alu_d   = alu_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      S_T2:  state_d = S_T3;
      S_T3: begin
        cls_d = dec_cls;
        alu_d = alu_code(opc);
        case (dec_cls)
          CLS_HALT: state_d = S_HALT;
          CLS_NOP:  state_d = S_T0;
          default:  state_d = S_T4;
        endcase
      end
      S_T4:  state_d = S_T5;
      S_T5:  state_d = (cls_q == CLS_ALU) ? S_T0 : S_T6;
      S_T6:  state_d = (cls_q == CLS_LD || cls_q == CLS_ST) ? S_T7 : S_T0;
      S_T7:  state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // State registers with synchronous clear
  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q <= S_RST;
      cls_q   <= CLS_NOP;
      alu_q   <= ALU_ADD;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      alu_q   <= alu_d;
    end
  end

  // Control strobes per state; only one bus source (incl. Rout) is ever active
  always_comb begin
    PCout     = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    MDRout    = 1'b0;
    Cout      = 1'b0;
    MARin     = 1'b0;
    PCin      = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin_low   = 1'b0;
    Zin_high  = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    operation = ALU_ADD;
    Run       = (state_q != S_HALT);
    rin_en    = 1'b0;
    rin_idx   = ra;
    rout_en   = 1'b0;
    rout_idx  = rb;
    case (state_q)
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin_low = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        case (dec_cls)
          CLS_ALU, CLS_LD, CLS_ST: begin
            rout_en  = 1'b1;
            rout_idx = rb;
            Yin      = 1'b1;
          end
`ifdef CU_MULDIV_EN
          CLS_MD: begin
            rout_en  = 1'b1;
            rout_idx = ra;
            Yin      = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T4: begin
        case (cls_q)
          CLS_ALU: begin
            rout_en   = 1'b1;
            rout_idx  = rc;
            operation = alu_q;
            Zin_low   = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            Cout    = 1'b1;
            Zin_low = 1'b1;
          end
`ifdef CU_MULDIV_EN
          CLS_MD: begin
            rout_en   = 1'b1;
            rout_idx  = rb;
            operation = alu_q;
            Zin_low   = 1'b1;
            Zin_high  = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T5: begin
        case (cls_q)
          CLS_ALU: begin
            Zlowout = 1'b1;
            rin_en  = 1'b1;
            rin_idx = ra;
          end
          CLS_LD, CLS_ST: begin
            Zlowout = 1'b1;
            MARin   = 1'b1;
          end
`ifdef CU_MULDIV_EN
          CLS_MD: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T6: begin
        case (cls_q)
          CLS_LD: begin
            Read  = 1'b1;
            MDRin = 1'b1;
          end
          CLS_ST: begin
            rout_en  = 1'b1;
            rout_idx = ra;
            MDRin    = 1'b1;
          end
`ifdef CU_MULDIV_EN
          CLS_MD: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T7: begin
        case (cls_q)
          CLS_LD: begin
            MDRout  = 1'b1;
            rin_en  = 1'b1;
            rin_idx = ra;
          end
          CLS_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  reg_select u_rin_sel (
    .idx    (rin_idx),
    .en     (rin_en),
    .onehot (Rin)
  );

  reg_select u_rout_sel (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle expected strobe vectors queued from a spec model.
// Latency: one expected entry per Clock, compared #1 after the rising edge.
// Backpressure: none; build with or without CU_MULDIV_EN to match the RTL.
module tb_control_unit;

`ifdef CU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  typedef struct packed {
    logic        pc_out, zlow_out, zhigh_out, hi_out, lo_out, mdr_out, c_out;
    logic        mar_in, pc_in, mdr_in, ir_in, y_in, zlow_in, zhigh_in, hi_in, lo_in;
    logic        inc_pc, rd, wr;
    logic [15:0] rin, rout;
    logic [3:0]  op;
    logic        run;
  } outs_t;

  logic        Clock, clear;
  logic [31:0] IR;
  logic PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout;
  logic MARin, PCin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin;
  logic IncPC, Read, Write, Run;
  logic [15:0] Rin, Rout;
  logic [3:0]  operation;

  control_unit dut (
    .Clock(Clock), .clear(clear), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .Cout(Cout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zin_low(Zin_low), .Zin_high(Zin_high), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .Rin(Rin), .Rout(Rout), .operation(operation), .Run(Run)
  );

  outs_t obs;
  assign obs = {PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout,
                MARin, PCin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin,
                IncPC, Read, Write, Rin, Rout, operation, Run};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int    checks   = 0;
  int    failures = 0;
  outs_t exp_q[$];
  string tag_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic outs_t idle();
    outs_t e;
    e     = '0;
    e.run = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {opc, ra, rb, rc, 15'h5a5a};
  endfunction

  task automatic push(input outs_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  // Spec model: expected strobe vector for every cycle of one instruction
  task automatic push_model(input logic [31:0] ir, input string name);
    outs_t      e;
    logic [4:0] opc;
    logic [3:0] ra, rb, rc, alu;
    opc = ir[31:27];
    ra  = ir[26:23];
    rb  = ir[22:19];
    rc  = ir[18:15];
    e = idle(); e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.zlow_in = 1; push(e, {name, "_T0"});
    e = idle(); e.zlow_out = 1; e.pc_in = 1; e.rd = 1; e.mdr_in = 1;     push(e, {name, "_T1"});
    e = idle(); e.mdr_out = 1; e.ir_in = 1;                              push(e, {name, "_T2"});
    case (opc)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        alu = (opc == 5'b00100) ? 4'b0001 : (opc == 5'b00101) ? 4'b0010 :
              (opc == 5'b00110) ? 4'b0011 : 4'b0000;
        e = idle(); e.rout = 16'(1) << rb; e.y_in = 1;                 push(e, {name, "_T3"});
        e = idle(); e.rout = 16'(1) << rc; e.op = alu; e.zlow_in = 1;  push(e, {name, "_T4"});
        e = idle(); e.zlow_out = 1; e.rin = 16'(1) << ra;              push(e, {name, "_T5"});
      end
      5'b00000, 5'b00010: begin
        e = idle(); e.rout = 16'(1) << rb; e.y_in = 1;                 push(e, {name, "_T3"});
        e = idle(); e.c_out = 1; e.zlow_in = 1;                        push(e, {name, "_T4"});
        e = idle(); e.zlow_out = 1; e.mar_in = 1;                      push(e, {name, "_T5"});
        if (opc == 5'b00000) begin
          e = idle(); e.rd = 1; e.mdr_in = 1;                          push(e, {name, "_T6"});
          e = idle(); e.mdr_out = 1; e.rin = 16'(1) << ra;             push(e, {name, "_T7"});
        end else begin
          e = idle(); e.rout = 16'(1) << ra; e.mdr_in = 1;             push(e, {name, "_T6"});
          e = idle(); e.wr = 1;                                        push(e, {name, "_T7"});
        end
      end
      5'b01111, 5'b10000: begin
        if (MD_EN) begin
          alu = (opc == 5'b01111) ? 4'b0100 : 4'b0101;
          e = idle(); e.rout = 16'(1) << ra; e.y_in = 1;               push(e, {name, "_T3"});
          e = idle(); e.rout = 16'(1) << rb; e.op = alu; e.zlow_in = 1; e.zhigh_in = 1;
          push(e, {name, "_T4"});
          e = idle(); e.zlow_out = 1; e.lo_in = 1;                     push(e, {name, "_T5"});
          e = idle(); e.zhigh_out = 1; e.hi_in = 1;                    push(e, {name, "_T6"});
        end else begin
          push(idle(), {name, "_T3"});
        end
      end
      5'b11011: begin
        push(idle(), {name, "_T3"});
        for (int k = 0; k < 20; k++) push('0, {name, "_halted"});
      end
      default: push(idle(), {name, "_T3"});
    endcase
  endtask

  task automatic compare_next();
    outs_t e;
    string t;
    int    srcs;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, 64'(obs), 64'(e));
    srcs = $countones({PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout, Rout});
    check({t, "_one_src"}, {63'd0, srcs <= 1}, 64'd1);
  endtask

  // Entered positioned in T0; leaves positioned in the state after the instruction.
  // abort_at >= 0 raises clear during that step and checks the reset response.
  task automatic run_instr(input logic [31:0] ir, input string name, input int abort_at);
    int n;
    push_model(ir, name);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      IR = (i < 2) ? $urandom : ir;
      #0;
      compare_next();
      if (i == abort_at) begin
        exp_q.delete();
        tag_q.delete();
        clear = 1'b1;
        step();
        check({name, "_clear_rst"}, 64'(obs), 64'(idle()));
        clear = 1'b0;
        step();
        return;
      end
      step();
    end
  endtask

  logic [4:0] ops [11];
  logic [4:0] rop;

  initial begin
    ops = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b01111, 5'b10000, 5'b11010, 5'b01001, 5'b11111};
    clear = 1'b1;
    IR    = 32'h0;
    step();
    step();
    check("reset_rst", 64'(obs), 64'(idle()));
    clear = 1'b0;
    step();

    run_instr(32'h18918000, "add", -1);
    run_instr(mk_ir(5'b00000, 4'd5, 4'd0, 4'd9), "ld", -1);
    run_instr(mk_ir(5'b00010, 4'd3, 4'd7, 4'd1), "st", -1);
    run_instr(mk_ir(5'b00100, 4'd15, 4'd14, 4'd0), "sub", -1);
    run_instr(mk_ir(5'b00101, 4'd6, 4'd6, 4'd6), "and", -1);
    run_instr(mk_ir(5'b00110, 4'd0, 4'd11, 4'd12), "or", -1);
    run_instr(mk_ir(5'b11010, 4'd2, 4'd3, 4'd4), "nop", -1);
    run_instr(mk_ir(5'b01001, 4'd2, 4'd3, 4'd4), "undef", -1);
    run_instr(mk_ir(5'b01111, 4'd1, 4'd2, 4'd0), "mul", -1);
    run_instr(mk_ir(5'b10000, 4'd9, 4'd4, 4'd0), "div", -1);
    run_instr(mk_ir(5'b00100, 4'd7, 4'd8, 4'd10), "sub_abort", 4);
    run_instr(mk_ir(5'b11011, 4'd0, 4'd0, 4'd0), "halt", -1);
    check("halt_stays", 64'(obs), 64'(0));
    clear = 1'b1;
    step();
    check("halt_clear_rst", 64'(obs), 64'(idle()));
    clear = 1'b0;
    step();
    run_instr(32'h18918000, "add_after_halt", -1);

    for (int j = 0; j < 16; j++) begin
      rop = ops[$urandom_range(0, 10)];
      run_instr(mk_ir(rop, 4'($urandom), 4'($urandom), 4'($urandom)), "rand", -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clock  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port clear  input  1  synchronous active-high reset, sampled on Clock rising edge.
REQ-003 SHALL have port IR  input  32  current instruction: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc.
REQ-004 SHALL have ports PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout  output  1 each  bus-source strobes.
REQ-005 SHALL have ports MARin, PCin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin  output  1 each  register load strobes.
REQ-006 SHALL have ports IncPC, Read, Write  output  1 each  PC increment and memory strobes.
REQ-007 SHALL have ports Rin, Rout  output  16 each  one-hot general-register load/drive, bit n = Rn.
REQ-008 SHALL have port operation  output  4  ALU opcode.
REQ-009 SHALL have port Run  output  1  high while not halted.

Function
REQ-010 SHALL implement FSM states RST, T0..T7, HALT; one state per Clock.
REQ-011 SHALL sequence fetch for every instruction: T0 PCout+MARin+IncPC+Zin_low; T1 Zlowout+PCin+Read+MDRin; T2 MDRout+IRin; then decode IR in T3.
REQ-012 SHALL sequence ADD/SUB/AND/OR: T3 Rout[Rb]+Yin; T4 Rout[Rc]+operation+Zin_low; T5 Zlowout+Rin[Ra]; next T0.
REQ-013 SHALL sequence LD: T3 Rout[Rb]+Yin; T4 Cout+operation=ADD+Zin_low; T5 Zlowout+MARin; T6 Read+MDRin; T7 MDRout+Rin[Ra]; next T0.
REQ-014 SHALL sequence ST: T3–T5 as LD; T6 Rout[Ra]+MDRin; T7 Write; next T0.
REQ-015 SHALL treat NOP and every undefined opcode as fetch-only (T3 -> T0, no strobes in T3).
REQ-016 SHALL enter HALT from T3 on opcode HALT; HALT is absorbing until clear; all strobes 0, Run=0.
REQ-017 SHALL assert at most one bus-source strobe (including Rout bits) per cycle.
REQ-018 SHALL hold operation at ADD (0000) in every state not listed otherwise.
REQ-019 SHALL take Ra/Rb/Rc only from IR sampled in T3..T7; IR changes outside those states have no effect.
REQ-020 SHALL use opcodes LD=00000, ST=00010, ADD=00011, SUB=00100, AND=00101, OR=00110, MUL=01111, DIV=10000, NOP=11010, HALT=11011; ALU codes ADD=0000, SUB=0001, AND=0010, OR=0011, MUL=0100, DIV=0101.

Reset
REQ-021 SHALL, on clear=1 at any state including mid-instruction, go to RST next cycle with every output 0 except Run=1.
REQ-022 SHALL leave RST for T0 on the first cycle with clear=0.

Configuration
REQ-023 SHALL, with CU_MULDIV_EN defined, sequence MUL/DIV: T3 Rout[Ra]+Yin; T4 Rout[Rb]+operation+Zin_low+Zin_high; T5 Zlowout+LOin; T6 Zhighout+HIin; next T0.
REQ-024 SHALL, without CU_MULDIV_EN, treat MUL/DIV as NOP and never assert HIin, LOin, Zin_high or Zhighout.

Structure
REQ-025 SHALL place opcode constants, ALU code constants and the state enum in shared package cu_pkg.
REQ-026 SHALL instantiate one sub-module reg_select converting 4-bit index plus enable into the 16-bit one-hot Rin/Rout.

Verification
REQ-027 SHALL cover ADD: IR=0x18918000 after clear -> T3 Rout=0x0004+Yin; T4 Rout=0x0008, operation=0000; T5 Zlowout, Rin=0x0002.
REQ-028 SHALL cover LD: IR opcode 00000, Ra=5, Rb=0 -> T4 Cout; T6 Read+MDRin; T7 MDRout, Rin=0x0020; 8 cycles per instruction.
REQ-029 SHALL cover ST: opcode 00010, Ra=3 -> T6 Rout=0x0008+MDRin; T7 Write=1 for exactly one cycle.
REQ-030 SHALL cover HALT: opcode 11011 -> Run=0 from cycle after T3, outputs 0 for 20 cycles; clear -> RST then T0 PCout.
REQ-031 SHALL cover clear asserted in T4 of SUB -> next cycle all strobes 0, Rin never asserted for that instruction.
REQ-032 SHALL cover MUL Ra=1, Rb=2 in both builds: defined -> T5 LOin, T6 HIin; undefined -> T3 returns to T0, no HI/LO strobes.
